// File: rtl/util_wdg_frontend.sv
// Heartbeat front-end for the watchdog: synchronises and glitch-filters hb_in,
// turns qualifying edges into monitor_out kicks and generates the cnt_pulse strobe.
module util_wdg_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              hb_in,
    input  logic [1:0]        edge_sel,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [31:0]       prescale,
    input  logic              cnt_clr,
    output logic              monitor_out,
    output logic              cnt_pulse,
    output logic              hb_level,
    output logic [31:0]       edge_cnt
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync;
    logic                   hb_level_q, hb_level_d;
    // Filtered level delayed by one enabled cycle, used for edge detection.
    logic                   hb_prev_q, hb_prev_d;
    logic [FILT_W-1:0]      fcnt_q, fcnt_d;
    logic [31:0]            pcnt_q, pcnt_d;
    logic                   monitor_q, monitor_d;
    logic                   pulse_q, pulse_d;
    logic [31:0]            edge_cnt_q, edge_cnt_d;

    function automatic logic kick_sel(input logic [1:0] sel, input logic lvl, input logic prev);
        logic k;
        case (sel)
            2'b00:   k = lvl & ~prev;
            2'b01:   k = ~lvl & prev;
            2'b10:   k = lvl ^ prev;
            default: k = lvl;
        endcase
        return k;
    endfunction

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], hb_in};
        hb_level_d = hb_level_q;
        hb_prev_d  = hb_prev_q;
        fcnt_d     = fcnt_q;
        pcnt_d     = pcnt_q;
        monitor_d  = monitor_q;
        pulse_d    = pulse_q;
        edge_cnt_d = edge_cnt_q;

        if (!en) begin
            // Loading both levels from sync keeps re-enable free of spurious edges.
            hb_level_d = sync;
            hb_prev_d  = sync;
            fcnt_d     = '0;
            pcnt_d     = '0;
            monitor_d  = 1'b0;
            pulse_d    = 1'b0;
        end else begin
            hb_prev_d = hb_level_q;
            monitor_d = kick_sel(edge_sel, hb_level_q, hb_prev_q);

            if (sync == hb_level_q) begin
                fcnt_d = '0;
            end else if (fcnt_q == filt_len) begin
                hb_level_d = sync;
                fcnt_d     = '0;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end

            if (pcnt_q >= prescale) begin
                pulse_d = 1'b1;
                pcnt_d  = '0;
            end else begin
                pulse_d = 1'b0;
                pcnt_d  = pcnt_q + 32'd1;
            end
        end

        if (cnt_clr) begin
            edge_cnt_d = '0;
        end else if (en && monitor_q && (edge_sel != 2'b11) && (edge_cnt_q != 32'hFFFF_FFFF)) begin
            edge_cnt_d = edge_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q     <= '0;
            hb_level_q <= 1'b0;
            hb_prev_q  <= 1'b0;
            fcnt_q     <= '0;
            pcnt_q     <= '0;
            monitor_q  <= 1'b0;
            pulse_q    <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            sync_q     <= sync_d;
            hb_level_q <= hb_level_d;
            hb_prev_q  <= hb_prev_d;
            fcnt_q     <= fcnt_d;
            pcnt_q     <= pcnt_d;
            monitor_q  <= monitor_d;
            pulse_q    <= pulse_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign monitor_out = monitor_q;
    assign cnt_pulse   = pulse_q;
    assign hb_level    = hb_level_q;
    assign edge_cnt    = edge_cnt_q;

endmodule

// File: tb/tb_util_wdg_frontend.sv
// Bench for util_wdg_frontend: directed table, hand sequences for corner cases and
// randomized traffic compared each cycle against a behavioural model.
module tb_util_wdg_frontend;

    localparam int S  = 2;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          hb_in;
    logic [1:0]    edge_sel;
    logic [FW-1:0] filt_len;
    logic [31:0]   prescale;
    logic          cnt_clr;
    logic          monitor_out;
    logic          cnt_pulse;
    logic          hb_level;
    logic [31:0]   edge_cnt;

    util_wdg_frontend #(.SYNC_STAGES(S), .FILT_W(FW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .hb_in       (hb_in),
        .edge_sel    (edge_sel),
        .filt_len    (filt_len),
        .prescale    (prescale),
        .cnt_clr     (cnt_clr),
        .monitor_out (monitor_out),
        .cnt_pulse   (cnt_pulse),
        .hb_level    (hb_level),
        .edge_cnt    (edge_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [S-1:0] m_sh;
    logic         m_lvl, m_prev, m_mon, m_pulse;
    int           m_run;
    longint       m_ecyc;
    logic [31:0]  m_cnt;

    typedef struct {
        logic [1:0] sel;
        int         flen;
        int         width;
        int         kicks;
        int         delta;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sh    = '0;
        m_lvl   = 1'b0;
        m_prev  = 1'b0;
        m_mon   = 1'b0;
        m_pulse = 1'b0;
        m_run   = 0;
        m_ecyc  = 0;
        m_cnt   = '0;
    endtask

    // One clock edge of the model: sync is a pure delay line, the filter accepts a
    // new level after filt_len+1 consecutive disagreeing samples, the strobe fires on
    // every (prescale+1)-th enabled cycle.
    task automatic model_step();
        logic s, k, old_lvl;
        s = m_sh[S-1];
        if (en) begin
            case (edge_sel)
                2'b00:   k = m_lvl && !m_prev;
                2'b01:   k = !m_lvl && m_prev;
                2'b10:   k = (m_lvl != m_prev);
                default: k = m_lvl;
            endcase
            if (cnt_clr) m_cnt = '0;
            else if (m_mon && edge_sel != 2'b11 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            old_lvl = m_lvl;
            if (s != m_lvl) begin
                m_run++;
                if (m_run > int'(filt_len)) begin
                    m_lvl = s;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_prev = old_lvl;
            m_ecyc++;
            m_pulse = ((m_ecyc % (longint'(prescale) + 1)) == 0);
            m_mon = k;
        end else begin
            if (cnt_clr) m_cnt = '0;
            m_lvl   = s;
            m_prev  = s;
            m_run   = 0;
            m_ecyc  = 0;
            m_mon   = 1'b0;
            m_pulse = 1'b0;
        end
        m_sh = {m_sh[S-2:0], hb_in};
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstn) model_step();
        @(negedge clk);
        chk("mdl_mon",   32'(monitor_out), 32'(m_mon));
        chk("mdl_pulse", 32'(cnt_pulse),   32'(m_pulse));
        chk("mdl_level", 32'(hb_level),    32'(m_lvl));
        chk("mdl_cnt",   edge_cnt,         m_cnt);
    endtask

    initial begin
        int   exp_total;
        int   kicks;
        int   run;
        logic found;

        tbl[0] = '{2'b00, 0, 3, 1, 1};
        tbl[1] = '{2'b01, 0, 3, 1, 1};
        tbl[2] = '{2'b10, 0, 3, 2, 2};
        tbl[3] = '{2'b00, 4, 4, 0, 0};
        tbl[4] = '{2'b00, 4, 5, 1, 1};
        tbl[5] = '{2'b10, 4, 4, 0, 0};
        tbl[6] = '{2'b10, 2, 3, 2, 2};
        tbl[7] = '{2'b01, 4, 5, 1, 1};
        tbl[8] = '{2'b11, 0, 3, 3, 0};
        tbl[9] = '{2'b11, 4, 5, 5, 0};

        rstn = 1'b0; en = 1'b1; hb_in = 1'b0; edge_sel = 2'b00;
        filt_len = '0; prescale = 32'd3; cnt_clr = 1'b0;
        model_reset();

        // Reset state
        repeat (3) tick();
        chk("rst_mon",   32'(monitor_out), 32'd0);
        chk("rst_pulse", 32'(cnt_pulse),   32'd0);
        chk("rst_level", 32'(hb_level),    32'd0);
        chk("rst_cnt",   edge_cnt,         32'd0);

        // Idle with prescale=3
        rstn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("idle_pulse", 32'(cnt_pulse),   32'((i % 4) == 0));
            chk("idle_mon",   32'(monitor_out), 32'd0);
        end
        chk("idle_cnt", edge_cnt, 32'd0);

        // Rising kick latency with filt_len=0
        hb_in = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            tick();
            chk("rise_mon",   32'(monitor_out), 32'(i == 3));
            chk("rise_level", 32'(hb_level),    32'(i >= 2));
        end
        chk("rise_cnt", edge_cnt, 32'd1);
        hb_in = 1'b0;
        kicks = 0;
        repeat (8) begin
            tick();
            if (monitor_out) kicks++;
        end
        chk("fall_nokick", 32'(kicks), 32'd0);
        exp_total = 1;

        // Table of pulse widths, filter lengths and edge modes
        for (int i = 0; i < 10; i++) begin
            en = 1'b0;
            edge_sel = tbl[i].sel;
            filt_len = FW'(tbl[i].flen);
            tick(); tick();
            en = 1'b1;
            tick(); tick();
            kicks = 0;
            hb_in = 1'b1;
            for (int c = 0; c < tbl[i].width; c++) begin
                tick();
                if (monitor_out) kicks++;
            end
            hb_in = 1'b0;
            repeat (20) begin
                tick();
                if (monitor_out) kicks++;
            end
            exp_total += tbl[i].delta;
            chk($sformatf("tbl%0d_kicks", i), 32'(kicks), 32'(tbl[i].kicks));
            chk($sformatf("tbl%0d_cnt", i), edge_cnt, 32'(exp_total));
        end

        // Saturation from a preloaded count
        en = 1'b0; edge_sel = 2'b00; filt_len = '0;
        tick(); tick();
        en = 1'b1;
        tick(); tick();
        force dut.edge_cnt_q = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.edge_cnt_q;
        repeat (3) begin
            hb_in = 1'b1;
            repeat (3) tick();
            hb_in = 1'b0;
            repeat (5) tick();
        end
        chk("sat_cnt", edge_cnt, 32'hFFFF_FFFF);

        // Clear in the same cycle as a kick
        hb_in = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            tick();
            if (monitor_out) found = 1'b1;
        end
        chk("clr_kick_seen", 32'(found), 32'd1);
        cnt_clr = 1'b1;
        tick();
        chk("clr_prio", edge_cnt, 32'd0);
        cnt_clr = 1'b0;
        hb_in = 1'b0;
        tick();
        chk("clr_hold", edge_cnt, 32'd0);
        repeat (4) tick();

        // Disable with pcnt=2, heartbeat rising while disabled
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (cnt_pulse) found = 1'b1;
        end
        chk("dis_pulse_seen", 32'(found), 32'd1);
        tick(); tick();
        en = 1'b0;
        hb_in = 1'b1;
        repeat (5) begin
            tick();
            chk("dis_mon",   32'(monitor_out), 32'd0);
            chk("dis_pulse", 32'(cnt_pulse),   32'd0);
        end
        chk("dis_level", 32'(hb_level), 32'd1);
        en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("reen_mon",   32'(monitor_out), 32'd0);
            chk("reen_pulse", 32'(cnt_pulse),   32'((i % 4) == 0));
        end
        chk("reen_cnt", edge_cnt, 32'd0);

        // Asynchronous reset mid-period
        en = 1'b0; prescale = 32'd0; edge_sel = 2'b11;
        repeat (3) tick();
        en = 1'b1;
        repeat (4) tick();
        chk("pre_rst_mon",   32'(monitor_out), 32'd1);
        chk("pre_rst_pulse", 32'(cnt_pulse),   32'd1);
        chk("pre_rst_level", 32'(hb_level),    32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_mon",   32'(monitor_out), 32'd0);
        chk("arst_pulse", 32'(cnt_pulse),   32'd0);
        chk("arst_level", 32'(hb_level),    32'd0);
        chk("arst_cnt",   edge_cnt,         32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        // Randomized traffic against the model
        for (int seg = 0; seg < 40; seg++) begin
            en = 1'b0;
            cnt_clr = 1'b0;
            edge_sel = 2'($urandom_range(0, 3));
            filt_len = FW'($urandom_range(0, 6));
            prescale = $urandom_range(0, 9);
            tick(); tick();
            run = 0;
            for (int c = 0; c < 60; c++) begin
                if (run == 0) begin
                    hb_in = ~hb_in;
                    run = int'($urandom_range(1, 9));
                end
                run--;
                en = ($urandom_range(0, 29) != 0);
                cnt_clr = ($urandom_range(0, 39) == 0);
                tick();
            end
        end
        cnt_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/util_wdg_frontend.md
# util_wdg_frontend

Heartbeat front-end that sits directly upstream of the watchdog timer. It synchronises and glitch-filters an asynchronous heartbeat input, then converts qualifying heartbeat edges into single-cycle `monitor_out` kicks. It also generates the programmable-rate `cnt_pulse` decrement strobe that the watchdog counts. A saturating edge counter is provided for status readback.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth; legal 2..4.
- `FILT_W`, 8: width of the glitch-filter length field and counter.
- `clk`  in  1  single clock for all logic.
- `rstn`  in  1  reset; asynchronous assert, active-low.
- `en`  in  1  block enable; low holds the block idle.
- `hb_in`  in  1  asynchronous heartbeat from an external source.
- `edge_sel`  in  2  kick qualifier: 00 rising, 01 falling, 10 both, 11 level-high.
- `filt_len`  in  FILT_W  extra stable cycles required before a level change is accepted.
- `prescale`  in  32  `cnt_pulse` period minus 1, in clk cycles.
- `cnt_clr`  in  1  synchronous clear of `edge_cnt`.
- `monitor_out`  out  1  kick to watchdog `monitor_in`; one-cycle pulse in edge modes.
- `cnt_pulse`  out  1  one-cycle decrement strobe to watchdog `cnt_pulse`.
- `hb_level`  out  1  filtered heartbeat level.
- `edge_cnt`  out  32  count of qualifying edges, saturating.

## Operation
- **Reset.** All registers clear to 0 on `rstn` low: sync chain, `hb_level`, `hb_level_d`, filter counter, prescaler counter, `monitor_out`, `cnt_pulse`, `edge_cnt`.
- **Synchroniser.** `SYNC_STAGES` flops in series, always clocking, including while `en` is low. `sync` is the last stage.
- **Glitch filter.**
  - If `sync == hb_level`, `fcnt <= 0`.
  - Otherwise, if `fcnt == filt_len`, then `hb_level <= sync` and `fcnt <= 0`.
  - Otherwise `fcnt <= fcnt + 1`.
  - A pulse shorter than `filt_len+1` cycles on `sync` is discarded.
  - A change of `filt_len` takes effect on the next compare. If `fcnt` already exceeds the new `filt_len`, the counter wraps at `2^FILT_W` with no special handling. Software changes `filt_len` only while `en=0`.
- **Edge detect.** `hb_level_d <= hb_level` every enabled cycle. The registered `monitor_out` is:
  - 00: `hb_level & ~hb_level_d`
  - 01: `~hb_level & hb_level_d`
  - 10: `hb_level ^ hb_level_d`
  - 11: `hb_level` (level, not pulsed)
- **Edge counter.**
  - `cnt_clr=1`: `edge_cnt <= 0`. Clear has priority over increment in the same cycle.
  - Otherwise, when `monitor_out` is 1 and `edge_sel != 11`, `edge_cnt` increments. It saturates at `0xFFFFFFFF`.
  - In level mode, `edge_cnt` holds.
  - `cnt_clr` is honoured even when `en=0`.
- **Prescaler.**
  - If `pcnt >= prescale`: `cnt_pulse <= 1` and `pcnt <= 0`.
  - Otherwise: `cnt_pulse <= 0` and `pcnt <= pcnt + 1`.
  - `prescale=0` gives `cnt_pulse` continuously high.
  - Lowering `prescale` below the current `pcnt` fires a pulse on the next cycle, then wraps.
- **Disable (`en=0`).**
  - `hb_level` and `hb_level_d` both load `sync`.
  - `fcnt`, `pcnt`, `monitor_out` and `cnt_pulse` go to 0.
  - `edge_cnt` holds.
  - On re-enable, no spurious edge is produced. The first `cnt_pulse` occurs `prescale+1` cycles after the first enabled edge.

## Timing
- Let edge k be the first clk edge that samples `hb_in` high:
  - `sync` is high after edge k+`SYNC_STAGES`-1.
  - `hb_level` is high after edge k+`SYNC_STAGES`+`filt_len`.
  - `monitor_out` is high for exactly the cycle after edge k+`SYNC_STAGES`+`filt_len`+1.
  - `edge_cnt` updates one edge after that.
- With defaults and `filt_len=0`, kick latency is 3 edges.
- The minimum accepted `hb_in` high or low width is `filt_len+1` cycles. Shorter pulses produce no `hb_level` change and no kick.
- `cnt_pulse` period is exactly `prescale+1` cycles with a 1-cycle width. It is independent of heartbeat activity.
- `rstn` assertion mid-operation clears all outputs immediately, with no clock needed. Deassertion is synchronised externally.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **Reset and idle.** Reset, then `en=1`, `prescale=3`, `hb_in=0` for 20 cycles -> `cnt_pulse` high on every 4th cycle; `monitor_out=0`; `edge_cnt=0`.
- **Rising kick.** `edge_sel=00`, `filt_len=0`, `hb_in` rises at edge k -> `monitor_out` high only in the cycle after edge k+3; `edge_cnt=1`. Falling edge produces no kick.
- **Glitch rejection.** `filt_len=4`, drive a 4-cycle `hb_in` pulse -> `hb_level` stays 0, no kick. A 5-cycle pulse -> one kick and `hb_level` high for 5 cycles.
- **Both-edge and level modes.** `edge_sel=10` with 3 full pulses -> 6 kicks, `edge_cnt=6`. `edge_sel=11` -> `monitor_out` tracks `hb_level` and `edge_cnt` holds at 6.
- **Saturation and clear.** Preload near max by forcing `edge_cnt=0xFFFFFFFE`, apply 3 kicks -> `edge_cnt=0xFFFFFFFF`. Assert `cnt_clr` in the same cycle as a kick -> `edge_cnt=0`.
- **Disable and reset mid-operation.**
  - Drop `en` with `hb_in=1` and `pcnt=2`, then re-raise `en` -> no kick; first `cnt_pulse` arrives `prescale+1` cycles later.
  - Assert `rstn` low asynchronously mid-period -> all outputs 0 before the next clk edge.
